// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder/loader: instruction classes,
// RV32I opcodes, ImmSrc format codes (same numbering as the control unit)
// and the loader state encoding.
// Optional feature macro: INSTR_READBACK_EN adds the S_VERIFY state.
package instr_pkg;

  // Instruction class carried on in_kind.
  typedef enum logic [2:0] {
    K_OP_IMM = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_OP     = 3'd3,
    K_BRANCH = 3'd4,
    K_JALR   = 3'd5,
    K_JAL    = 3'd6,
    K_LUI    = 3'd7
  } kind_t;

  // RV32I major opcodes.
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // ImmSrc codes, numbered as the control unit decodes them.
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Loader states; S_VERIFY only exists with read-back checking.
  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_DONE
`ifdef INSTR_READBACK_EN
    ,
    S_VERIFY
`endif
  } state_t;

endpackage

// File: rtl/instr_word_pack.sv
// Combinational encoder: decoded instruction fields -> 32-bit RV32I word plus
// a legality flag covering immediate ranges and supported funct3 values.
// Ports: kind/funct3/sub/rd/rs1/rs2/imm in; word, legal out.
module instr_word_pack
  import instr_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  funct3,
  input  logic        sub,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  logic signed [31:0] simm;
  logic               i_ok;
  logic               b_ok;
  logic               j_ok;
  logic               shamt_ok;
  logic [6:0]         opc;
  logic [2:0]         src;
  logic               r_type;

  assign simm     = imm;
  assign i_ok     = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  assign b_ok     = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm[0];
  assign j_ok     = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm[0];
  assign shamt_ok = (imm[31:5] == 27'd0);

  // Per-class opcode, format and legality.
  always_comb begin
    opc    = OPC_OP_IMM;
    src    = IMM_I;
    r_type = 1'b0;
    legal  = 1'b0;
    unique case (kind_t'(kind))
      K_OP_IMM: begin
        opc   = OPC_OP_IMM;
        legal = i_ok && (funct3 != 3'b001 || shamt_ok) && !sub;
      end
      K_LOAD: begin
        opc   = OPC_LOAD;
        legal = i_ok && (funct3 == 3'b010) && !sub;
      end
      K_STORE: begin
        opc   = OPC_STORE;
        src   = IMM_S;
        legal = i_ok && (funct3 == 3'b010) && !sub;
      end
      K_OP: begin
        opc    = OPC_OP;
        r_type = 1'b1;
        legal  = !sub || (funct3 == 3'b000);
      end
      K_BRANCH: begin
        opc   = OPC_BRANCH;
        src   = IMM_B;
        legal = b_ok && (funct3[2:1] == 2'b00) && !sub;
      end
      K_JALR: begin
        opc   = OPC_JALR;
        legal = i_ok && (funct3 == 3'b000) && !sub;
      end
      K_JAL: begin
        opc   = OPC_JAL;
        src   = IMM_J;
        legal = j_ok && !sub;
      end
      K_LUI: begin
        opc   = OPC_LUI;
        src   = IMM_U;
        legal = (imm[11:0] == 12'd0) && !sub;
      end
      default: legal = 1'b0;
    endcase
  end

  // Bit placement per format.
  always_comb begin
    word = '0;
    if (r_type) begin
      word = {1'b0, sub, 5'b00000, rs2, rs1, funct3, rd, opc};
    end else begin
      unique case (src)
        IMM_I:   word = {imm[11:0], rs1, funct3, rd, opc};
        IMM_S:   word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opc};
        IMM_B:   word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opc};
        IMM_J:   word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
        IMM_U:   word = {imm[31:12], rd, opc};
        default: word = '0;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts decoded instruction bundles over valid/ready,
// encodes them and writes each word to instruction memory at an
// auto-incrementing, non-wrapping word address.
// Ports: clk, rst (sync, active-high); in_* bundle handshake; mem_we/mem_addr/
// mem_wdata write port, mem_rdata read-back; done/full/err sticky flags; count.
// Optional feature macro: INSTR_READBACK_EN (read back and compare each word).
module instr_encoder_loader
  import instr_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_kind,
  input  logic [2:0]            in_funct3,
  input  logic                  in_sub,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  done,
  output logic                  full,
  output logic                  err,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned CNT_W = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   ptr;
  logic                    last_q;
  logic [31:0]             pack_word;
  logic                    pack_legal;

`ifdef INSTR_READBACK_EN
  logic                    finish_q;
`else
  logic                    unused_rdata;
  assign unused_rdata = ^mem_rdata;
`endif

  instr_word_pack u_pack (
    .kind   (in_kind),
    .funct3 (in_funct3),
    .sub    (in_sub),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .imm    (in_imm),
    .word   (pack_word),
    .legal  (pack_legal)
  );

  // Loader FSM; mem_wdata doubles as the held word for read-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      last_q    <= 1'b0;
      in_ready  <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      full      <= 1'b0;
      err       <= 1'b0;
      count     <= '0;
`ifdef INSTR_READBACK_EN
      finish_q  <= 1'b0;
`endif
    end else begin
      mem_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (pack_legal) begin
              mem_we    <= 1'b1;
              mem_addr  <= ptr;
              mem_wdata <= pack_word;
              last_q    <= in_last;
              in_ready  <= 1'b0;
              state     <= S_WRITE;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          count <= count + CNT_W'(1);
          // Pointer saturates at the top address; full marks that slot used.
          if (ptr == PTR_MAX) full <= 1'b1;
          else                ptr  <= ptr + ADDR_WIDTH'(1);
`ifdef INSTR_READBACK_EN
          finish_q <= last_q || (ptr == PTR_MAX);
          state    <= S_VERIFY;
`else
          if (last_q || (ptr == PTR_MAX)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
`endif
        end
`ifdef INSTR_READBACK_EN
        // mem_addr still points at the word just written.
        S_VERIFY: begin
          if (mem_rdata != mem_wdata) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (finish_q) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
`endif
        S_DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: one instance at the default
// address width and one at ADDR_WIDTH=2 for memory-full behaviour.
module tb_instr_encoder_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  kind;
  logic [2:0]  f3;
  logic        sub;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        last;
  logic        rdzero;

  logic        valid_a, ready_a, we_a, done_a, full_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a, rdata_a;
  logic [8:0]  count_a;

  logic        valid_b, ready_b, we_b, done_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b, rdata_b;
  logic [2:0]  count_b;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [4];

  always @(posedge clk) if (we_a) mem_a[addr_a] <= wdata_a;
  always @(posedge clk) if (we_b) mem_b[addr_b] <= wdata_b;
  assign rdata_a = rdzero ? 32'd0 : mem_a[addr_a];
  assign rdata_b = mem_b[addr_b];

  instr_encoder_loader #(.ADDR_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(valid_a), .in_ready(ready_a),
    .in_kind(kind), .in_funct3(f3), .in_sub(sub), .in_rd(rd), .in_rs1(rs1),
    .in_rs2(rs2), .in_imm(imm), .in_last(last), .mem_we(we_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_rdata(rdata_a),
    .done(done_a), .full(full_a), .err(err_a), .count(count_a)
  );

  instr_encoder_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(ready_b),
    .in_kind(kind), .in_funct3(f3), .in_sub(sub), .in_rd(rd), .in_rs1(rs1),
    .in_rs2(rs2), .in_imm(imm), .in_last(last), .mem_we(we_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_rdata(rdata_b),
    .done(done_b), .full(full_b), .err(err_b), .count(count_b)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_fields(input logic [2:0] k, input logic [2:0] f, input logic s,
                            input logic [4:0] d, input logic [4:0] a, input logic [4:0] b,
                            input logic [31:0] i, input logic l);
    kind = k; f3 = f; sub = s; rd = d; rs1 = a; rs2 = b; imm = i; last = l;
  endtask

  task automatic push_a();
    valid_a = 1'b1;
    @(posedge clk); #1;
    valid_a = 1'b0;
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (!ready_a && !done_a && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_back"}, 32'(ready_a | done_a), 32'd1);
  endtask

  // Legal bundle: expect the write strobe exactly one cycle after accept.
  task automatic write_a(input string tag, input logic [7:0] exp_addr, input logic [31:0] exp_word);
    push_a();
    chk({tag, "_we"}, 32'(we_a), 32'd1);
    chk({tag, "_addr"}, 32'(addr_a), 32'(exp_addr));
    chk({tag, "_wdata"}, wdata_a, exp_word);
    chk({tag, "_rdy"}, 32'(ready_a), 32'd0);
    wait_idle_a(tag);
  endtask

  task automatic reject_a(input string tag, input logic [8:0] exp_count);
    push_a();
    chk({tag, "_err"}, 32'(err_a), 32'd1);
    chk({tag, "_we"}, 32'(we_a), 32'd0);
    chk({tag, "_cnt"}, 32'(count_a), 32'(exp_count));
    chk({tag, "_rdy"}, 32'(ready_a), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic saw_we;
    rst = 1'b1; valid_a = 1'b0; valid_b = 1'b0; rdzero = 1'b0;
    set_fields(3'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_a), 32'd1);
    chk("rst_we", 32'(we_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_full", 32'(full_a), 32'd0);
    chk("rst_err", 32'(err_a), 32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_addr", 32'(addr_a), 32'd0);
    rst = 1'b0;

    set_fields(3'd0, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    write_a("addi", 8'd0, 32'h00500093);
    chk("addi_err", 32'(err_a), 32'd0);
    set_fields(3'd7, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
    write_a("lui", 8'd1, 32'h123452B7);
    set_fields(3'd3, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
    write_a("sub", 8'd2, 32'h402081B3);
    set_fields(3'd4, 3'b001, 1'b0, 5'd0, 5'd1, 5'd2, -32'sd8, 1'b0);
    write_a("bne", 8'd3, 32'hFE209CE3);
    set_fields(3'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
    write_a("jal", 8'd4, 32'h001000EF);
    set_fields(3'd2, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
    write_a("sw", 8'd5, 32'h0020A423);
    set_fields(3'd0, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, -32'sd2048, 1'b0);
    write_a("addi_min", 8'd6, 32'h80000093);
    chk("seq_count", 32'(count_a), 32'd7);

    set_fields(3'd6, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0);
    reject_a("jal_odd", 9'd7);
    set_fields(3'd1, 3'b000, 1'b0, 5'd1, 5'd2, 5'd0, 32'd0, 1'b0);
    reject_a("lw_f3", 9'd7);

    do_reset();
    chk("rst2_err", 32'(err_a), 32'd0);
    chk("rst2_count", 32'(count_a), 32'd0);
    set_fields(3'd0, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0);
    reject_a("addi_big", 9'd0);
    set_fields(3'd0, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    write_a("addi_m1", 8'd0, 32'hFFF00113);
    chk("addi_m1_cnt", 32'(count_a), 32'd1);

    // Reset while the write strobe is high.
    set_fields(3'd0, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    push_a();
    chk("midrst_we1", 32'(we_a), 32'd1);
    do_reset();
    chk("midrst_we0", 32'(we_a), 32'd0);
    chk("midrst_cnt", 32'(count_a), 32'd0);
    chk("midrst_rdy", 32'(ready_a), 32'd1);
    chk("midrst_err", 32'(err_a), 32'd0);

    set_fields(3'd0, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
    write_a("last", 8'd0, 32'h00500093);
    chk("last_done", 32'(done_a), 32'd1);
    chk("last_rdy", 32'(ready_a), 32'd0);
    chk("last_full", 32'(full_a), 32'd0);
    chk("last_cnt", 32'(count_a), 32'd1);
    saw_we = 1'b0;
    valid_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      saw_we |= we_a;
    end
    valid_a = 1'b0;
    chk("done_nowrite", 32'(saw_we), 32'd0);

`ifdef INSTR_READBACK_EN
    do_reset();
    rdzero = 1'b1;
    set_fields(3'd0, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
    push_a();
    repeat (3) @(posedge clk);
    #1;
    chk("rb_err", 32'(err_a), 32'd1);
    chk("rb_done", 32'(done_a), 32'd1);
    rdzero = 1'b0;
`endif

    // Small memory fills up after four writes.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int n;
      set_fields(3'd0, 3'b000, 1'b0, 5'(i), 5'd0, 5'd0, 32'(i), 1'b0);
      valid_b = 1'b1;
      @(posedge clk); #1;
      valid_b = 1'b0;
      chk("fill_we", 32'(we_b), 32'd1);
      chk("fill_addr", 32'(addr_b), 32'(i));
      chk("fill_wdata", wdata_b, {12'(i), 5'd0, 3'b000, 5'(i), 7'b0010011});
      n = 0;
      while (!ready_b && !done_b && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      chk("fill_back", 32'(ready_b | done_b), 32'd1);
    end
    chk("full_full", 32'(full_b), 32'd1);
    chk("full_done", 32'(done_b), 32'd1);
    chk("full_cnt", 32'(count_b), 32'd4);
    chk("full_rdy", 32'(ready_b), 32'd0);
    saw_we = 1'b0;
    valid_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      saw_we |= we_b;
    end
    valid_b = 1'b0;
    chk("full_nowrite", 32'(saw_we), 32'd0);
    chk("full_cnt2", 32'(count_b), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Producer side of the instruction word consumed by the control unit. Accepts decoded instruction fields over a valid/ready handshake.
- Encodes each instruction into a 32-bit RV32I word, range-checks it, and writes it into instruction memory at an auto-incrementing word address.
- Used as the boot/program loader and as the stimulus source for CPU-level benches.
- Covers exactly the instruction classes and funct3 values the control unit decodes.

Parameters:
- ADDR_WIDTH, 8, word-address width of instruction memory. Capacity is 2**ADDR_WIDTH words.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  field bundle valid
- in_ready  out  1  loader can accept a bundle
- in_kind  in  3  class: 0 OP_IMM, 1 LOAD, 2 STORE, 3 OP, 4 BRANCH, 5 JALR, 6 JAL, 7 LUI
- in_funct3  in  3  funct3
- in_sub  in  1  funct7[5] (OP only)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  signed byte immediate; for LUI the full upper value
- in_last  in  1  final instruction of program
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  word address
- mem_wdata  out  32  encoded word
- mem_rdata  in  32  read data, used only with the optional feature
- done  out  1  sticky: program complete or memory full
- full  out  1  sticky: last address written
- err  out  1  sticky: a bundle was rejected
- count  out  ADDR_WIDTH+1  words written

Behaviour:
- Reset values: all outputs 0, except in_ready = 1. State S_IDLE, write pointer 0.
- Reset mid-operation: any pending write is aborted and mem_we is 0 the next cycle.
- S_IDLE:
  - in_ready = 1.
  - Accept occurs on in_valid && in_ready.
  - Legal bundle: register the encoded word, go to S_WRITE.
  - Illegal bundle: set err, drop the bundle, pointer unchanged, stay in S_IDLE.
- S_WRITE:
  - in_ready = 0.
  - mem_we = 1 for exactly one cycle, with mem_addr = pointer and mem_wdata = registered word. This is the cycle after accept.
  - Then pointer+1 and count+1.
  - in_last = 1, or pointer == 2**ADDR_WIDTH-1 → S_DONE. If the pointer was at its maximum, also set full.
  - Otherwise → S_IDLE.
- Throughput: one instruction per 2 cycles.
- S_DONE: in_ready = 0 and done = 1 until rst. The pointer never wraps.
- Formats (ImmSrc numbering shared with the control unit):
  - I (000): OP_IMM 0010011, LOAD 0000011, JALR 1100111.
  - S (001): STORE 0100011.
  - B (010): BRANCH 1100011.
  - J (011): JAL 1101111.
  - U (100): LUI 0110111.
  - R: OP 0110011, funct7 = {1'b0, in_sub, 5'b0}.
- Legality; anything else sets err:
  - I/S immediate in -2048..2047.
  - B immediate in -4096..4094 and even.
  - J immediate in ±1 MiB and even.
  - LUI requires in_imm[11:0] == 0.
  - BRANCH funct3 ∈ {000, 001}.
  - JALR, LOAD and STORE funct3 == 010 for LOAD/STORE, 000 for JALR.
  - OP_IMM shift (funct3 001) requires imm in 0..31.
  - in_sub = 1 is only legal for OP with funct3 000.
- Fields not used by a format are ignored.

Optional Feature:
- Macro: INSTR_READBACK_EN.
- When defined:
  - S_WRITE → S_VERIFY.
  - In S_VERIFY, mem_addr holds the written address with mem_we = 0. mem_rdata is compared one cycle later.
  - On mismatch, set err and go to S_DONE.
  - Throughput drops to one instruction per 3 cycles.
- When undefined: no S_VERIFY state and mem_rdata is unused.

Decomposition:
- Package instr_pkg:
  - kind_t enum.
  - Opcode constants.
  - ImmSrc constants (shared with the control unit).
  - State enum.
- Sub-module instr_word_pack: combinational fields → {word, legal}. The top level holds the FSM, pointer and flags.

Test Plan:
- addi x1,x0,5 (kind 0, f3 000, imm 5) → mem_we one cycle after accept, addr 0, wdata 0x00500093. Then lui x5,0x12345000 → addr 1, wdata 0x123452B7.
- sub x3,x1,x2 (kind 3, in_sub 1) → 0x402081B3. bne x1,x2,-8 → 0xFE209CE3.
- jal x1,+2048 → 0x001000EF. jal with odd imm 3 → err = 1, no mem_we, count unchanged.
- addi imm 4096 → err = 1, pointer stays 0. The next legal addi writes addr 0.
- ADDR_WIDTH = 2, 4 legal bundles with in_last = 0 → full = 1, done = 1, count = 4, in_ready = 0. A 5th in_valid is never accepted.
- rst asserted in S_WRITE → mem_we 0 next cycle, count 0, in_ready 1. With INSTR_READBACK_EN and mem_rdata forced to 0 → err = 1, done = 1.
